// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous flagged FIFO.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // The occupancy count needs one bit more than the pointers to represent DEPTH.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH flop array: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [fifo_depth(ADDR_WIDTH)];

  // Contents are deliberately not reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = fifo_depth(ADDR_WIDTH) - 32'd2,
  parameter int unsigned AE_THRESH  = 2,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned   LW        = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(fifo_depth(ADDR_WIDTH));
  localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;
  fifo_status_t          st;

  // Flags come only from registered state, so no request input reaches an output.
  always_comb begin
    st              = '0;
    st.empty        = (level_q == '0);
    st.full         = (level_q == DEPTH_LVL);
    st.almost_empty = (level_q <= AE_LVL);
    st.almost_full  = (level_q >= AF_LVL);
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  assign wr_acc = wr_en && !st.full;
  assign rd_acc = rd_en && !st.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as clr_err must survive the clear.
    ovf_d = (wr_en && st.full)  || (ovf_q && !clr_err);
    unf_d = (rd_en && st.empty) || (unf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head is shown directly; masked to zero while empty so reset reads back 0.
      assign rd_data  = st.empty ? '0 : ram_rdata;
      assign rd_valid = !st.empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= ram_rdata;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  assign level        = level_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_flags;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [4:0] s_level, f_level;
  logic       s_ovf, f_ovf, s_unf, f_unf;

  sync_fifo_flags #(.FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  sync_fifo_flags #(.FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rv  = 1'b0;
  logic [7:0] m_rd  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int unsigned n;
    n = q.size();
    chk({ctx, ":level"},     32'(s_level),    n);
    chk({ctx, ":f_level"},   32'(f_level),    n);
    chk({ctx, ":empty"},     32'(s_empty),    32'(n == 0));
    chk({ctx, ":f_empty"},   32'(f_empty),    32'(n == 0));
    chk({ctx, ":full"},      32'(s_full),     32'(n == DEPTH));
    chk({ctx, ":f_full"},    32'(f_full),     32'(n == DEPTH));
    chk({ctx, ":ae"},        32'(s_ae),       32'(n <= 2));
    chk({ctx, ":f_ae"},      32'(f_ae),       32'(n <= 2));
    chk({ctx, ":af"},        32'(s_af),       32'(n >= DEPTH - 2));
    chk({ctx, ":f_af"},      32'(f_af),       32'(n >= DEPTH - 2));
    chk({ctx, ":ovf"},       32'(s_ovf),      32'(m_ovf));
    chk({ctx, ":f_ovf"},     32'(f_ovf),      32'(m_ovf));
    chk({ctx, ":unf"},       32'(s_unf),      32'(m_unf));
    chk({ctx, ":f_unf"},     32'(f_unf),      32'(m_unf));
    chk({ctx, ":rv"},        32'(s_rd_valid), 32'(m_rv));
    chk({ctx, ":rd"},        32'(s_rd_data),  32'(m_rd));
    chk({ctx, ":f_rv"},      32'(f_rd_valid), 32'(n != 0));
    chk({ctx, ":f_rd"},      32'(f_rd_data),  (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input string ctx, input logic rst, input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    logic was_full, was_empty;
    rst_n   = rst;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = 8'h00;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = (w && was_full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
      m_rv  = r && !was_empty;
      if (r && !was_empty) m_rd = q.pop_front();
      if (w && !was_full)  q.push_back(d);
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;

    // Reset held with a write pending
    step("reset0", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step("reset1", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);

    // Fill to full, one extra write, then drain
    for (int unsigned i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    step("fill_over", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    for (int unsigned i = 0; i < DEPTH; i++) step("drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr_ovf", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap the pointers, then hold level 5 with simultaneous traffic
    for (int unsigned i = 0; i < 10; i++) step("wrap_w", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 10; i++) step("wrap_r", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 5; i++)  step("lvl5", 1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 12; i++) step("wr_rd", 1'b1, 1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
    for (int unsigned i = 0; i < 5; i++)  step("wrap_drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow and clear priority
    step("unf_set", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step("unf_set_clr", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step("unf_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fall-through head visibility
    step("fwft_wr", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    step("fwft_pop", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation discards contents
    for (int unsigned i = 0; i < 7; i++) step("pre_rst", 1'b1, 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    step("mid_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("post_wr", 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    step("post_rd", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with a drifting write/read bias to visit both extremes
    for (int unsigned i = 0; i < 3000; i++) begin
      int unsigned wp;
      logic rst, w, r, c;
      wp  = ((i / 200) % 2 == 0) ? 70 : 30;
      rst = ($urandom_range(0, 499) != 0);
      w   = ($urandom_range(0, 99) < wp);
      r   = ($urandom_range(0, 99) < (100 - wp));
      c   = ($urandom_range(0, 19) == 0);
      step("rand", rst, w, 8'($urandom), r, c);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
